// File: rtl/mem_bank_writer.sv
// Write-side front end for a single-bank simple-dual-port memory.
// Sweeps the bank with DEFAULT_VALUE after reset or on request, then issues
// buffered host writes to the bank write port one per cycle.
module mem_bank_writer #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    DEPTH         = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter int                    FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(DEPTH)-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     clearing,
  output logic                     clear_done,
  output logic                     wea,
  output logic [$clog2(DEPTH)-1:0] addra,
  output logic [DATA_WIDTH-1:0]    dia
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   sweep, sweep_nx;

  logic [AW-1:0]         fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (count < CNT_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == RUN) && !clear && (count != '0);

  // Next state and sweep address; clear restarts the sweep, and because the
  // clear edge already issues address 0 the sweep resumes at address 1.
  always_comb begin
    state_nx = state;
    sweep_nx = sweep;
    if (clear) begin
      state_nx = CLEAR;
      sweep_nx = AW'(1);
    end else if (state == CLEAR) begin
      if (sweep == ADDR_LAST) begin
        state_nx = RUN;
        sweep_nx = '0;
      end else begin
        sweep_nx = sweep + 1'b1;
      end
    end
  end

  // State and sweep address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      sweep <= '0;
    end else begin
      state <= state_nx;
      sweep <= sweep_nx;
    end
  end

  // Registered memory write port and sweep status flags.
  // clearing stays high through the cycle showing the last sweep write; the
  // first RUN cycle with clearing still set is exactly the clear_done cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wea        <= 1'b0;
      addra      <= '0;
      dia        <= '0;
      clearing   <= 1'b1;
      clear_done <= 1'b0;
    end else begin
      clearing   <= clear || (state == CLEAR);
      clear_done <= (state == RUN) && clearing && !clear;
      if (clear || state == CLEAR) begin
        wea   <= 1'b1;
        addra <= clear ? '0 : sweep;
        dia   <= DEFAULT_VALUE;
      end else if (pop) begin
        wea   <= 1'b1;
        addra <= fifo_addr[rd_ptr];
        dia   <= fifo_data[rd_ptr];
      end else begin
        wea   <= 1'b0;
      end
    end
  end

  // FIFO storage; entries carry no reset since count qualifies them.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_addr[wr_ptr] <= in_addr;
      fifo_data[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; clear drops old entries but keeps a same-edge push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (clear) begin
        rd_ptr <= wr_ptr;
        count  <= push ? CW'(1) : '0;
      end else begin
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bank_writer.sv
// Directed vector bench for mem_bank_writer (DEPTH=8, FIFO_DEPTH=4, DEFAULT=5A).
module tb_mem_bank_writer;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_addr;
  logic [7:0] in_data;
  logic       clearing;
  logic       clear_done;
  logic       wea;
  logic [2:0] addra;
  logic [7:0] dia;

  int n_vec = 0;
  int n_bad = 0;

  mem_bank_writer #(
    .DATA_WIDTH   (8),
    .DEPTH        (8),
    .DEFAULT_VALUE(8'h5A),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .clearing  (clearing),
    .clear_done(clear_done),
    .wea       (wea),
    .addra     (addra),
    .dia       (dia)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       rst;
    logic       clr;
    logic       vld;
    logic [2:0] a;
    logic [7:0] d;
    logic       e_wea;
    logic [2:0] e_addra;
    logic [7:0] e_dia;
    logic       e_clearing;
    logic       e_done;
    logic       e_ready;
  } vec_t;

  function automatic vec_t mk(input string name, input logic rst, input logic clr,
                              input logic vld, input logic [2:0] a, input logic [7:0] d,
                              input logic ew, input logic [2:0] ea, input logic [7:0] ed,
                              input logic ec, input logic edn, input logic er);
    vec_t v;
    v.name = name; v.rst = rst; v.clr = clr; v.vld = vld; v.a = a; v.d = d;
    v.e_wea = ew; v.e_addra = ea; v.e_dia = ed;
    v.e_clearing = ec; v.e_done = edn; v.e_ready = er;
    return v;
  endfunction

  // Drive one vector before an edge, then check the registered result after it.
  task automatic apply(input vec_t v);
    reset    = v.rst;
    clear    = v.clr;
    in_valid = v.vld;
    in_addr  = v.a;
    in_data  = v.d;
    @(posedge clk);
    #1;
    n_vec++;
    if ({wea, addra, dia, clearing, clear_done, in_ready} !==
        {v.e_wea, v.e_addra, v.e_dia, v.e_clearing, v.e_done, v.e_ready}) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got wea=%b addra=%0d dia=%h clearing=%b clear_done=%b in_ready=%b, expected wea=%b addra=%0d dia=%h clearing=%b clear_done=%b in_ready=%b",
               v.name, n_vec, wea, addra, dia, clearing, clear_done, in_ready,
               v.e_wea, v.e_addra, v.e_dia, v.e_clearing, v.e_done, v.e_ready);
    end
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;

    // Reset, power-up sweep, single write, streaming.
    tbl.push_back(mk("reset", 1,0,0, 3'd0, 8'h00,  0, 3'd0, 8'h00, 1,0,1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk("sweep", 0,0,0, 3'd0, 8'h00,  1, 3'(i), 8'h5A, 1,0,1));
    tbl.push_back(mk("sweep_done", 0,0,0, 3'd0, 8'h00,  0, 3'd7, 8'h5A, 0,1,1));
    tbl.push_back(mk("idle",       0,0,0, 3'd0, 8'h00,  0, 3'd7, 8'h5A, 0,0,1));
    tbl.push_back(mk("wr_accept",  0,0,1, 3'd3, 8'hC4,  0, 3'd7, 8'h5A, 0,0,1));
    tbl.push_back(mk("wr_issue",   0,0,0, 3'd0, 8'h00,  1, 3'd3, 8'hC4, 0,0,1));
    tbl.push_back(mk("wr_after",   0,0,0, 3'd0, 8'h00,  0, 3'd3, 8'hC4, 0,0,1));
    tbl.push_back(mk("stream",     0,0,1, 3'd0, 8'h10,  0, 3'd3, 8'hC4, 0,0,1));
    for (int i = 1; i < 6; i++)
      tbl.push_back(mk("stream", 0,0,1, 3'(i), 8'(8'h10 + i),
                       1, 3'(i - 1), 8'(8'h10 + i - 1), 0,0,1));
    tbl.push_back(mk("stream_tail", 0,0,0, 3'd0, 8'h00,  1, 3'd5, 8'h15, 0,0,1));
    tbl.push_back(mk("stream_idle", 0,0,0, 3'd0, 8'h00,  0, 3'd5, 8'h15, 0,0,1));
    foreach (tbl[i]) apply(tbl[i]);

    // Back-pressure during a sweep: only four pushes fit; B5..B7 are refused.
    apply(mk("bp_clear", 0,1,0, 3'd0, 8'h00,  1, 3'd0, 8'h5A, 1,0,1));
    for (int k = 1; k < 8; k++)
      apply(mk("bp_hold", 0,0,1, 3'(k), 8'(8'hB0 + k),  1, 3'(k), 8'h5A, 1,0, (k < 4)));
    for (int k = 1; k < 5; k++)
      apply(mk("bp_drain", 0,0,0, 3'd0, 8'h00,  1, 3'(k), 8'(8'hB0 + k), 0, (k == 1), 1));
    apply(mk("bp_idle", 0,0,0, 3'd0, 8'h00,  0, 3'd4, 8'hB4, 0,0,1));

    // Clear in RUN with three queued writes and a same-edge push.
    apply(mk("cq_clear", 0,1,0, 3'd0, 8'h00,  1, 3'd0, 8'h5A, 1,0,1));
    for (int k = 1; k < 5; k++)
      apply(mk("cq_fill", 0,0,1, 3'(k), 8'(8'hC0 + k),  1, 3'(k), 8'h5A, 1,0, (k < 4)));
    for (int k = 5; k < 8; k++)
      apply(mk("cq_sweep", 0,0,0, 3'd0, 8'h00,  1, 3'(k), 8'h5A, 1,0,0));
    apply(mk("cq_first_pop", 0,0,0, 3'd0, 8'h00,  1, 3'd1, 8'hC1, 0,1,1));
    apply(mk("cq_clear_push", 0,1,1, 3'd6, 8'h77,  1, 3'd0, 8'h5A, 1,0,1));
    for (int k = 1; k < 8; k++)
      apply(mk("cq_resweep", 0,0,0, 3'd0, 8'h00,  1, 3'(k), 8'h5A, 1,0,1));
    apply(mk("cq_kept_push", 0,0,0, 3'd0, 8'h00,  1, 3'd6, 8'h77, 0,1,1));
    apply(mk("cq_idle",      0,0,0, 3'd0, 8'h00,  0, 3'd6, 8'h77, 0,0,1));

    // Clear mid-sweep at addra=4, then reset mid-sweep with a queued write.
    apply(mk("ms_clear", 0,1,0, 3'd0, 8'h00,  1, 3'd0, 8'h5A, 1,0,1));
    for (int k = 1; k < 5; k++)
      apply(mk("ms_sweep", 0,0,0, 3'd0, 8'h00,  1, 3'(k), 8'h5A, 1,0,1));
    apply(mk("ms_restart", 0,1,0, 3'd0, 8'h00,  1, 3'd0, 8'h5A, 1,0,1));
    apply(mk("ms_push",    0,0,1, 3'd2, 8'h99,  1, 3'd1, 8'h5A, 1,0,1));
    apply(mk("ms_sweep2",  0,0,0, 3'd0, 8'h00,  1, 3'd2, 8'h5A, 1,0,1));
    apply(mk("ms_sweep3",  0,0,0, 3'd0, 8'h00,  1, 3'd3, 8'h5A, 1,0,1));
    apply(mk("ms_reset",   1,0,0, 3'd0, 8'h00,  0, 3'd0, 8'h00, 1,0,1));
    for (int k = 0; k < 8; k++)
      apply(mk("ms_post_reset_sweep", 0,0,0, 3'd0, 8'h00,  1, 3'(k), 8'h5A, 1,0,1));
    apply(mk("ms_done_fifo_empty", 0,0,0, 3'd0, 8'h00,  0, 3'd7, 8'h5A, 0,1,1));
    apply(mk("ms_idle",            0,0,0, 3'd0, 8'h00,  0, 3'd7, 8'h5A, 0,0,1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
